// File: rtl/ram_bus_arb_pkg.sv
// Shared types and constants for the two-master SRAM bus arbiter.
// Port indices double as grant values and request-vector bit positions.
package ram_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } arb_state_e;

    localparam logic PORT_VIDEO = 1'b0;
    localparam logic PORT_CPU   = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_bus_rr_pick.sv
// Combinational 2-way round-robin picker: a sole requester wins, a tie goes
// to the port that was not granted last. Zero latency, no backpressure.
module ram_bus_rr_pick
    import ram_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = PORT_VIDEO;
        if (&req) begin
            grant = ~last_grant;
        end else if (req[PORT_CPU]) begin
            grant = PORT_CPU;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the external SRAM bus between video/DMA (port 0) and CPU (port 1).
// One access per WAIT_CYCLES+2 cycles; masters hold req until their one-cycle ack.
module ram_bus_arbiter
    import ram_bus_arb_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_cpu,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [7:0]        m0_wdata,
    output logic              m0_ack,
    output logic [7:0]        m0_rdata,

    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [7:0]        m1_wdata,
    output logic              m1_ack,
    output logic [7:0]        m1_rdata,

    output logic              ram_enable,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_out,
    input  logic [7:0]        ram_data_in
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              ram_enable_q, ram_enable_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [7:0]        ram_data_out_q, ram_data_out_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [7:0]        m0_rdata_q, m0_rdata_d;
    logic [7:0]        m1_rdata_q, m1_rdata_d;

    logic pick_grant;
    logic pick_vld;

    ram_bus_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_vld)
    );

    // last_grant doubles as the owner of the access in flight.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        ram_enable_d   = ram_enable_q;
        ram_write_d    = ram_write_q;
        ram_address_d  = ram_address_q;
        ram_data_out_d = ram_data_out_q;
        m0_ack_d       = 1'b0;
        m1_ack_d       = 1'b0;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;

        case (state_q)
            IDLE: begin
                ram_enable_d = 1'b0;
                if (pick_vld) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_INIT;
                    last_grant_d = pick_grant;
                    ram_enable_d = 1'b1;
                    if (pick_grant == PORT_CPU) begin
                        ram_write_d    = m1_write;
                        ram_address_d  = m1_addr;
                        ram_data_out_d = m1_wdata;
                    end else begin
                        ram_write_d    = m0_write;
                        ram_address_d  = m0_addr;
                        ram_data_out_d = m0_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (!ram_write_q) begin
                        if (last_grant_q == PORT_CPU) begin
                            m1_rdata_d = ram_data_in;
                        end else begin
                            m0_rdata_d = ram_data_in;
                        end
                    end
                    if (last_grant_q == PORT_CPU) begin
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_ack_d = 1'b1;
                    end
                    ram_enable_d = 1'b0;
                    ram_write_d  = 1'b0;
                    state_d      = TURN;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_grant_q   <= PORT_CPU;
            ram_enable_q   <= 1'b0;
            ram_write_q    <= 1'b0;
            ram_address_q  <= '0;
            ram_data_out_q <= '0;
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            ram_enable_q   <= ram_enable_d;
            ram_write_q    <= ram_write_d;
            ram_address_q  <= ram_address_d;
            ram_data_out_q <= ram_data_out_d;
            m0_ack_q       <= m0_ack_d;
            m1_ack_q       <= m1_ack_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

    assign ram_enable   = ram_enable_q;
    assign ram_write    = ram_write_q;
    assign ram_address  = ram_address_q;
    assign ram_data_out = ram_data_out_q;
    assign m0_ack       = m0_ack_q;
    assign m1_ack       = m1_ack_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: timeline model for the WAIT_CYCLES=2 instance,
// directed literal checks for both the WAIT_CYCLES=2 and WAIT_CYCLES=1 instances.
module tb_ram_bus_arbiter;

    localparam int AW = 21;
    localparam int WC = 2;

    logic          clk_cpu = 1'b0;
    logic          reset;
    logic          m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]    m0_wdata = '0, m1_wdata = '0, ram_data_in = '0;
    logic          m0_ack, m1_ack, ram_enable, ram_write;
    logic [7:0]    m0_rdata, m1_rdata, ram_data_out;
    logic [AW-1:0] ram_address;

    logic          d1_req = 1'b0, d1_zero = 1'b0;
    logic [AW-1:0] d1_addr = '0, d1_zero_addr = '0;
    logic [7:0]    d1_rdin = '0, d1_zero_dat = '0;
    logic          d1_m0_ack, d1_m1_ack, d1_ram_enable, d1_ram_write;
    logic [7:0]    d1_m0_rdata, d1_m1_rdata, d1_ram_data_out;
    logic [AW-1:0] d1_ram_address;

    int tests = 0;
    int fails = 0;

    always #5 clk_cpu = ~clk_cpu;

    ram_bus_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
    );

    ram_bus_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
        .clk_cpu(clk_cpu), .reset(reset),
        .m0_req(d1_req), .m0_write(d1_zero), .m0_addr(d1_addr), .m0_wdata(d1_zero_dat),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
        .m1_req(d1_zero), .m1_write(d1_zero), .m1_addr(d1_zero_addr), .m1_wdata(d1_zero_dat),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .ram_enable(d1_ram_enable), .ram_write(d1_ram_write), .ram_address(d1_ram_address),
        .ram_data_out(d1_ram_data_out), .ram_data_in(d1_rdin)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Timeline model: an access granted at edge E owns the bus until its ack
    // edge E+WC; the bus is free for a new grant from edge E+WC+2 onwards.
    int            n, m_e, m_free;
    logic          m_busy, m_last;
    logic          e_en, e_wr, e_ack0, e_ack1;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_dout, e_rd0, e_rd1;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        return (r0 && r1) ? ~last : r1;
    endfunction

    always @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            n <= 0; m_e <= 0; m_free <= 0; m_busy <= 1'b0; m_last <= 1'b1;
            e_en <= 1'b0; e_wr <= 1'b0; e_ack0 <= 1'b0; e_ack1 <= 1'b0;
            e_addr <= '0; e_dout <= '0; e_rd0 <= '0; e_rd1 <= '0;
        end else begin
            n      <= n + 1;
            e_ack0 <= 1'b0;
            e_ack1 <= 1'b0;
            if (m_busy) begin
                if (n + 1 == m_e + WC) begin
                    if (!e_wr) begin
                        if (m_last) e_rd1 <= ram_data_in;
                        else        e_rd0 <= ram_data_in;
                    end
                    if (m_last) e_ack1 <= 1'b1;
                    else        e_ack0 <= 1'b1;
                    e_en   <= 1'b0;
                    e_wr   <= 1'b0;
                    m_busy <= 1'b0;
                    m_free <= n + 3;
                end
            end else if (n + 1 >= m_free && (m0_req || m1_req)) begin
                m_last <= pick(m0_req, m1_req, m_last);
                m_e    <= n + 1;
                m_busy <= 1'b1;
                e_en   <= 1'b1;
                e_wr   <= pick(m0_req, m1_req, m_last) ? m1_write : m0_write;
                e_addr <= pick(m0_req, m1_req, m_last) ? m1_addr  : m0_addr;
                e_dout <= pick(m0_req, m1_req, m_last) ? m1_wdata : m0_wdata;
            end
        end
    end

    always @(negedge clk_cpu) begin
        if (!reset) begin
            check("cyc_ram_enable",   32'(ram_enable),   32'(e_en));
            check("cyc_ram_write",    32'(ram_write),    32'(e_wr));
            check("cyc_ram_address",  32'(ram_address),  32'(e_addr));
            check("cyc_ram_data_out", 32'(ram_data_out), 32'(e_dout));
            check("cyc_m0_ack",       32'(m0_ack),       32'(e_ack0));
            check("cyc_m1_ack",       32'(m1_ack),       32'(e_ack1));
            check("cyc_m0_rdata",     32'(m0_rdata),     32'(e_rd0));
            check("cyc_m1_rdata",     32'(m1_rdata),     32'(e_rd1));
        end
    end

    // Event log used by the directed literal checks.
    int            ack_port[$];
    int            ack_cyc[$];
    int            en_total = 0;
    logic [AW-1:0] en_addr = '0;
    logic          en_wr = 1'b0;

    always @(negedge clk_cpu) begin
        if (!reset) begin
            if (ram_enable) begin
                en_total <= en_total + 1;
                en_addr  <= ram_address;
                en_wr    <= ram_write;
            end
            if (m0_ack) begin ack_port.push_back(0); ack_cyc.push_back(n); end
            if (m1_ack) begin ack_port.push_back(1); ack_cyc.push_back(n); end
        end
    end

    // Master: hold req until ack, drop for one cycle, then issue the next access.
    task automatic master(input bit p, input int count, input logic wr,
                          input logic [AW-1:0] base, input logic [7:0] wd);
        int t;
        for (int i = 0; i < count; i++) begin
            if (p) begin
                m1_write = wr; m1_addr = base + AW'(i); m1_wdata = wd + 8'(i); m1_req = 1'b1;
            end else begin
                m0_write = wr; m0_addr = base + AW'(i); m0_wdata = wd + 8'(i); m0_req = 1'b1;
            end
            t = 0;
            do begin
                @(negedge clk_cpu);
                t++;
            end while (!(p ? m1_ack : m0_ack) && t < 40);
            check(p ? "m1_ack_timeout" : "m0_ack_timeout", 32'(p ? m1_ack : m0_ack), 32'd1);
            if (p) m1_req = 1'b0;
            else   m0_req = 1'b0;
            @(negedge clk_cpu);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_cpu);
        #1;
    endtask

    int s, qi, e0;
    int d1_acks, d1_ack1, d1_ack2, d1_en, d1_en_k1, d1_m1_seen;

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk_cpu);
        #1;
        check("rst_ram_enable",   32'(ram_enable),   32'd0);
        check("rst_ram_write",    32'(ram_write),    32'd0);
        check("rst_ram_address",  32'(ram_address),  32'd0);
        check("rst_ram_data_out", 32'(ram_data_out), 32'd0);
        check("rst_acks",         32'({m0_ack, m1_ack}),     32'd0);
        check("rst_rdata",        32'({m0_rdata, m1_rdata}), 32'd0);
        @(negedge clk_cpu);
        #2 reset = 1'b0;

        // Single read on port 0.
        ram_data_in = 8'hA5;
        @(negedge clk_cpu);
        s = n; qi = ack_port.size(); e0 = en_total;
        master(1'b0, 1, 1'b0, 21'h00123, 8'h00);
        settle();
        check("t1_ack_count", 32'(ack_port.size() - qi), 32'd1);
        check("t1_ack_port",  32'(ack_port[qi]),         32'd0);
        check("t1_ack_lat",   32'(ack_cyc[qi] - s),      32'd3);
        check("t1_en_cycles", 32'(en_total - e0),        32'd2);
        check("t1_addr",      32'(en_addr),              32'h00123);
        check("t1_write",     32'(en_wr),                32'd0);
        check("t1_m0_rdata",  32'(m0_rdata),             32'hA5);

        // Single write on port 1 at the top address.
        ram_data_in = 8'h77;
        @(negedge clk_cpu);
        qi = ack_port.size(); e0 = en_total;
        master(1'b1, 1, 1'b1, 21'h1FFFFF, 8'h3C);
        settle();
        check("t2_ack_port",  32'(ack_port[qi]),  32'd1);
        check("t2_en_cycles", 32'(en_total - e0), 32'd2);
        check("t2_write",     32'(en_wr),         32'd1);
        check("t2_addr",      32'(en_addr),       32'h1FFFFF);
        check("t2_data_out",  32'(ram_data_out),  32'h3C);
        check("t2_wr_clear",  32'(ram_write),     32'd0);
        check("t2_m1_rdata",  32'(m1_rdata),      32'd0);

        // Contention: grants alternate starting with port 0, one per 4 cycles.
        ram_data_in = 8'h11;
        @(negedge clk_cpu);
        qi = ack_port.size();
        fork
            master(1'b0, 2, 1'b0, 21'h00010, 8'h00);
            master(1'b1, 2, 1'b0, 21'h00020, 8'h00);
        join
        settle();
        check("t3_ack_count", 32'(ack_port.size() - qi), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'(ack_port[qi + i]), 32'(i % 2));
            if (i > 0) check("t3_spacing", 32'(ack_cyc[qi + i] - ack_cyc[qi + i - 1]), 32'd4);
        end

        // Back-to-back reads from port 1 alone.
        ram_data_in = 8'h42;
        @(negedge clk_cpu);
        qi = ack_port.size(); e0 = en_total;
        master(1'b1, 3, 1'b0, 21'h0C000, 8'h00);
        settle();
        check("t4_ack_count", 32'(ack_port.size() - qi), 32'd3);
        check("t4_spacing_a", 32'(ack_cyc[qi + 1] - ack_cyc[qi]),     32'd4);
        check("t4_spacing_b", 32'(ack_cyc[qi + 2] - ack_cyc[qi + 1]), 32'd4);
        check("t4_en_cycles", 32'(en_total - e0), 32'd6);
        check("t4_m1_rdata",  32'(m1_rdata),      32'h42);

        // Reset during the second enable cycle of a port-0 read.
        ram_data_in = 8'h99;
        @(negedge clk_cpu);
        m0_write = 1'b0; m0_addr = 21'h0AAAA; m0_req = 1'b1;
        @(negedge clk_cpu);
        check("t5_en_first", 32'(ram_enable), 32'd1);
        @(negedge clk_cpu);
        #2 reset = 1'b1;
        #1;
        check("t5_en_reset",  32'(ram_enable), 32'd0);
        check("t5_ack_reset", 32'(m0_ack),     32'd0);
        m0_req = 1'b0;
        qi = ack_port.size();
        @(negedge clk_cpu);
        #2 reset = 1'b0;
        repeat (6) @(negedge clk_cpu);
        #1;
        check("t5_no_ack",   32'(ack_port.size() - qi), 32'd0);
        check("t5_m0_rdata", 32'(m0_rdata),             32'd0);
        @(negedge clk_cpu);
        fork
            master(1'b0, 1, 1'b0, 21'h00001, 8'h00);
            master(1'b1, 1, 1'b0, 21'h00002, 8'h00);
        join
        settle();
        check("t5_ack_count", 32'(ack_port.size() - qi), 32'd2);
        check("t5_first_p0",  32'(ack_port[qi]),         32'd0);
        check("t5_second_p1", 32'(ack_port[qi + 1]),     32'd1);

        // WAIT_CYCLES=1 instance: two reads, one-cycle enable, 3-cycle period.
        d1_rdin = 8'h5A;
        @(negedge clk_cpu);
        d1_addr = 21'h0ABCD; d1_req = 1'b1;
        d1_acks = 0; d1_ack1 = 0; d1_ack2 = 0; d1_en = 0; d1_en_k1 = 0; d1_m1_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_cpu);
            if (d1_ram_enable) d1_en++;
            if (k == 1) d1_en_k1 = int'(d1_ram_enable);
            if (d1_m1_ack) d1_m1_seen++;
            if (d1_m0_ack) begin
                if (d1_acks == 0) d1_ack1 = k;
                else              d1_ack2 = k;
                d1_acks++;
                d1_req = 1'b0;
            end else if (!d1_req && d1_acks == 1) begin
                d1_req = 1'b1;
            end
        end
        check("w1_en_first",  32'(d1_en_k1),    32'd1);
        check("w1_ack1_pos",  32'(d1_ack1),     32'd2);
        check("w1_ack2_pos",  32'(d1_ack2),     32'd5);
        check("w1_en_cycles", 32'(d1_en),       32'd2);
        check("w1_rdata",     32'(d1_m0_rdata), 32'h5A);
        check("w1_m1_ack",    32'(d1_m1_seen),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
